noc_credit_alloc: RTL and testbench
===================================

Name: noc_credit_alloc

Overview:
- Output-port allocator for the 4-port (E/W/S/N) NoC router.
- Each input FIFO head presents a valid bit and a 2-bit destination. Per cycle, the block grants at most one input per output port using per-output round-robin pointers.
- Downstream buffer credits are tracked per output port; no flit is granted to a port with zero credits.
- Grants drive FIFO read enables; registered selects drive the crossbar/output register stage.

Parameters:
- CREDITS, 4, downstream buffer depth per output port; credit counter reset value.
- CW, 3, credit counter width; must satisfy 2^CW > CREDITS.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset.
- req_valid  in  4  head-flit valid per input; index 0=E, 1=W, 2=S, 3=N.
- req_dest  in  8  destination of input i at bits [2i+1:2i]; encoding 00=E, 01=W, 10=S, 11=N.
- credit_ret  in  4  one-cycle pulse per output port; downstream freed one slot.
- grant  out  4  combinational; input i's head flit is consumed this cycle.
- out_valid  out  4  registered; output port o carries a flit next stage.
- out_sel  out  8  registered; source input for output o at bits [2o+1:2o].
- credit_cnt  out  4*CW  registered; credits of output o at bits [CW*(o+1)-1:CW*o].
- credit_err  out  4  registered, sticky; credit overflow on output o.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values (reset_n=0):
  - credit_cnt = CREDITS for all ports.
  - rr_ptr[o] = 0 (internal 2-bit pointer per output).
  - out_valid = 0, out_sel = 0, credit_err = 0.
  - grant forced to 0 while reset_n=0.
- Candidate set for output o: inputs i with req_valid[i]=1 and dest_i=o. Each input targets exactly one output, so grant is at most one per input.
- Winner selection: if credit_cnt[o]>0 and the candidate set is non-empty, the winner is the first candidate scanning i = rr_ptr[o], rr_ptr[o]+1, ... mod 4.
- grant[winner]=1 in the same cycle, combinationally. A requester may observe grant and drop or advance req_valid in the same cycle.
- Registered at posedge when output o has a winner:
  - out_valid[o]=1.
  - out_sel[o]=winner.
  - rr_ptr[o]=winner+1 mod 4; a winner of 3 wraps to 0.
- No winner for output o (no candidates or credit_cnt[o]=0):
  - out_valid[o]=0.
  - out_sel[o] and rr_ptr[o] hold.
  - Losing inputs get grant=0 and keep their flit at the FIFO head; nothing is dequeued or dropped.
- Credit update per output: next = cnt - win[o] + credit_ret[o].
  - Simultaneous grant and return: count unchanged.
  - Return with cnt=CREDITS and no grant: cnt holds at CREDITS and credit_err[o] sets, sticky until reset.
  - Grant is impossible at cnt=0, so no underflow can occur.
- A return arriving at cnt=0 enables a grant in the next cycle, not the same cycle. The credit check uses the registered count only.
- Latency:
  - Request to grant: 0 cycles.
  - Grant to out_valid/out_sel: 1 cycle.
  - Credit return to usable credit: 1 cycle.
- Fairness: with N persistent requesters on one output, each is granted once every N grants. No starvation bound larger than 4 grants.
- Reset mid-operation: all state cleared asynchronously; pending grants deassert immediately; a returned credit is lost and counters restart at CREDITS.
- req_dest is ignored when req_valid=0.

Test Plan:
- Reset, then hold all requests idle -> grant=0000, out_valid=0000, every credit_cnt=4, credit_err=0000.
- Inputs E/W/S/N all valid with dest=S (10) for 8 cycles, credit_ret[S] pulsed every cycle:
  - grant sequence is 0001, 0010, 0100, 1000, then repeats.
  - out_sel[S] registered sequence is 0, 1, 2, 3, 0, 1, 2, 3.
  - credit_cnt[S] stays 4.
- Input W valid to E, no credit returns:
  - 4 consecutive grants occur, with credit_cnt[E] going 4, 3, 2, 1, 0.
  - 5th cycle: grant=0000 and out_valid[E]=0.
  - Pulse credit_ret[E]: cnt becomes 1 and grant[W]=1 the following cycle.
- E to N, W to S, S to E, N to W all valid simultaneously -> grant=1111 in one cycle; next cycle out_valid=1111 and out_sel = {N:0, S:1, E:2, W:3}.
- At credit_cnt[W]=4, pulse credit_ret[W] with no grant -> cnt stays 4 and credit_err[W]=1 persists until reset_n low.
- Assert reset_n=0 mid-burst with credit_cnt[S]=1 -> grant=0 immediately; after release, cnt=4 and rr_ptr restarts so input E wins first.

Source files
------------

// File: rtl/noc_credit_alloc.sv
// Output-port allocator for a 4-port NoC router: per-output round-robin
// arbitration gated by downstream credit counters.
module noc_credit_alloc #(
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [3:0]      req_valid,
    input  logic [7:0]      req_dest,
    input  logic [3:0]      credit_ret,
    output logic [3:0]      grant,
    output logic [3:0]      out_valid,
    output logic [7:0]      out_sel,
    output logic [4*CW-1:0] credit_cnt,
    output logic [3:0]      credit_err
);

    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

    logic [3:0][3:0]    cand_s;
    logic [3:0]         win_s;
    logic [3:0][1:0]    winner_s;
    logic [3:0]         grant_s;
    logic [3:0][CW-1:0] credit_nxt_s;
    logic [3:0]         ovf_s;

    logic [3:0][1:0]    rr_ptr_r;
    logic [3:0][CW-1:0] credit_r;
    logic [3:0]         out_valid_r;
    logic [3:0][1:0]    out_sel_r;
    logic [3:0]         credit_err_r;

    // Returns {found, index} of the first set bit of cand scanning from ptr upward, mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            res = cand[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    // Candidate matrix: cand_s[o][i] is set when input i requests output o.
    always_comb begin
        cand_s = '0;
        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 4; i++) begin
                cand_s[o][i] = req_valid[i] & (req_dest[2*i +: 2] == 2'(o));
            end
        end
    end

    // Per-output arbitration; only the registered count gates a grant.
    always_comb begin
        win_s    = '0;
        winner_s = '0;
        for (int o = 0; o < 4; o++) begin
            logic [2:0] pick;
            pick        = rr_pick(cand_s[o], rr_ptr_r[o]);
            win_s[o]    = pick[2] & (credit_r[o] != {CW{1'b0}});
            winner_s[o] = pick[1:0];
        end
    end

    // Fold per-output winners back onto the input-side grant vector.
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < 4; i++) begin
            for (int o = 0; o < 4; o++) begin
                grant_s[i] = grant_s[i] | (win_s[o] & (winner_s[o] == 2'(i)));
            end
        end
    end

    // Credit bookkeeping; a return with the counter already full saturates and flags.
    always_comb begin
        credit_nxt_s = credit_r;
        ovf_s        = '0;
        for (int o = 0; o < 4; o++) begin
            case ({win_s[o], credit_ret[o]})
                2'b10: begin
                    credit_nxt_s[o] = credit_r[o] - CW'(1);
                    ovf_s[o]        = 1'b0;
                end
                2'b01: begin
                    if (credit_r[o] == CREDIT_MAX) begin
                        credit_nxt_s[o] = credit_r[o];
                        ovf_s[o]        = 1'b1;
                    end else begin
                        credit_nxt_s[o] = credit_r[o] + CW'(1);
                        ovf_s[o]        = 1'b0;
                    end
                end
                default: begin
                    credit_nxt_s[o] = credit_r[o];
                    ovf_s[o]        = 1'b0;
                end
            endcase
        end
    end

    // State registers: pointers, output selects, credits and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r     <= '0;
            out_valid_r  <= 4'b0000;
            out_sel_r    <= '0;
            credit_err_r <= 4'b0000;
            for (int o = 0; o < 4; o++) begin
                credit_r[o] <= CREDIT_MAX;
            end
        end else begin
            for (int o = 0; o < 4; o++) begin
                if (win_s[o]) begin
                    out_valid_r[o] <= 1'b1;
                    out_sel_r[o]   <= winner_s[o];
                    rr_ptr_r[o]    <= winner_s[o] + 2'd1;
                end else begin
                    out_valid_r[o] <= 1'b0;
                end
                credit_r[o]     <= credit_nxt_s[o];
                credit_err_r[o] <= credit_err_r[o] | ovf_s[o];
            end
        end
    end

    // Grants are suppressed immediately while reset is asserted.
    assign grant      = grant_s & {4{reset_n}};
    assign out_valid  = out_valid_r;
    assign out_sel    = out_sel_r;
    assign credit_cnt = credit_r;
    assign credit_err = credit_err_r;

endmodule

// File: tb/tb_noc_credit_alloc.sv
// Directed self-checking bench for noc_credit_alloc: arbitration order,
// credit exhaustion/recovery, full crossbar, overflow flag and mid-run reset.
module tb_noc_credit_alloc;

    localparam int CREDITS = 4;
    localparam int CW      = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [3:0]      req_valid;
    logic [7:0]      req_dest;
    logic [3:0]      credit_ret;
    logic [3:0]      grant;
    logic [3:0]      out_valid;
    logic [7:0]      out_sel;
    logic [4*CW-1:0] credit_cnt;
    logic [3:0]      credit_err;

    int checks = 0;
    int errors = 0;

    noc_credit_alloc #(.CREDITS(CREDITS), .CW(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_dest   (req_dest),
        .credit_ret (credit_ret),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_sel    (out_sel),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int o);
        return credit_cnt[CW*o +: CW];
    endfunction

    initial begin
        logic [3:0] exp_g;

        // Reset with requests present: grant must stay low
        reset_n    = 1'b0;
        req_valid  = 4'hF;
        req_dest   = 8'hAA;
        credit_ret = 4'h0;
        #12;
        chk("grant_in_reset", 32'(grant), 32'h0);
        @(negedge clk);
        reset_n   = 1'b1;
        req_valid = 4'h0;
        #1 chk("idle_grant", 32'(grant), 32'h0);
        @(posedge clk);
        #1;
        chk("idle_out_valid", 32'(out_valid), 32'h0);
        chk("idle_credit_cnt", 32'(credit_cnt), 32'h924);
        chk("idle_credit_err", 32'(credit_err), 32'h0);

        // All four inputs to S, return S credit every cycle
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid  = 4'hF;
            req_dest   = 8'hAA;
            credit_ret = 4'b0100;
            exp_g      = 4'b0001 << (k % 4);
            #1 chk("rr_grant", 32'(grant), 32'(exp_g));
            @(posedge clk);
            #1;
            chk("rr_out_sel_s", 32'(out_sel[5:4]), 32'(k % 4));
            chk("rr_out_valid", 32'(out_valid), 32'h4);
            chk("rr_cnt_s", 32'(cnt_of(2)), 32'd4);
        end

        // W to E with no returns: four grants drain E
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_valid  = 4'b0010;
            req_dest   = 8'h00;
            credit_ret = 4'h0;
            #1 chk("drain_grant", 32'(grant), 32'h2);
            @(posedge clk);
            #1 chk("drain_cnt_e", 32'(cnt_of(0)), 32'(3 - k));
        end
        @(negedge clk);
        #1 chk("empty_grant", 32'(grant), 32'h0);
        @(posedge clk);
        #1;
        chk("empty_out_valid", 32'(out_valid), 32'h0);
        chk("empty_out_sel_e", 32'(out_sel[1:0]), 32'd1);
        @(negedge clk);
        credit_ret = 4'b0001;
        #1 chk("ret_same_cycle_grant", 32'(grant), 32'h0);
        @(posedge clk);
        #1 chk("ret_cnt_e", 32'(cnt_of(0)), 32'd1);
        @(negedge clk);
        credit_ret = 4'h0;
        #1 chk("ret_next_grant", 32'(grant), 32'h2);
        @(posedge clk);
        #1;
        chk("ret_out_valid", 32'(out_valid), 32'h1);
        chk("ret_cnt_e_zero", 32'(cnt_of(0)), 32'd0);

        // Refill E
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_valid  = 4'h0;
            credit_ret = 4'b0001;
        end
        @(posedge clk);
        #1;
        chk("refill_cnt", 32'(credit_cnt), 32'h924);
        chk("refill_err", 32'(credit_err), 32'h0);

        // Full crossbar: E->N, W->S, S->E, N->W
        @(negedge clk);
        credit_ret = 4'h0;
        req_valid  = 4'hF;
        req_dest   = 8'b01_00_10_11;
        #1 chk("xbar_grant", 32'(grant), 32'hF);
        @(posedge clk);
        #1;
        chk("xbar_out_valid", 32'(out_valid), 32'hF);
        chk("xbar_out_sel", 32'(out_sel), 32'(8'b00_01_11_10));
        chk("xbar_cnt", 32'(credit_cnt), 32'h6DB);
        @(negedge clk);
        req_valid  = 4'h0;
        credit_ret = 4'hF;
        @(posedge clk);
        #1 chk("xbar_refill_cnt", 32'(credit_cnt), 32'h924);

        // Overflow on W is sticky
        @(negedge clk);
        credit_ret = 4'b0010;
        @(posedge clk);
        #1;
        chk("ovf_cnt_w", 32'(cnt_of(1)), 32'd4);
        chk("ovf_err", 32'(credit_err), 32'h2);
        @(negedge clk);
        credit_ret = 4'h0;
        @(negedge clk);
        #1 chk("ovf_err_sticky", 32'(credit_err), 32'h2);

        // Burst to S from rr_ptr[S]=2, then reset mid-burst at cnt=1
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'hF;
            req_dest  = 8'hAA;
            exp_g     = 4'b0001 << ((k + 2) % 4);
            #1 chk("burst_grant", 32'(grant), 32'(exp_g));
            @(posedge clk);
            #1 chk("burst_cnt_s", 32'(cnt_of(2)), 32'(3 - k));
        end
        @(negedge clk);
        #1 chk("burst_grant_w", 32'(grant), 32'h2);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_cnt", 32'(credit_cnt), 32'h924);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_err", 32'(credit_err), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("post_rst_grant", 32'(grant), 32'h1);
        @(posedge clk);
        #1;
        chk("post_rst_cnt_s", 32'(cnt_of(2)), 32'd3);
        chk("post_rst_sel_s", 32'(out_sel[5:4]), 32'd0);
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
